// File: rtl/multicycle_select_adder.sv
// Iterative wide adder/subtractor. Operands are captured on start, then one
// BLOCK_WIDTH slice is resolved per clock, LSB slice first. Each slice uses
// a carry-select stage, and the registered running carry picks the sum.
module multicycle_select_adder #(
  parameter int OPERAND_WIDTH = 64,
  parameter int BLOCK_WIDTH   = 8
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic                     iStart,
  input  logic                     iSub,
  input  logic [OPERAND_WIDTH-1:0] iA,
  input  logic [OPERAND_WIDTH-1:0] iB,
  input  logic                     iCarry,
  output logic                     oBusy,
  output logic                     oDone,
  output logic [OPERAND_WIDTH-1:0] oSum,
  output logic                     oCarry,
  output logic                     oOverflow
);

  localparam int NUM_BLOCKS = OPERAND_WIDTH / BLOCK_WIDTH;
  localparam int CNT_W      = $clog2(NUM_BLOCKS) + 1;

  generate
    if ((OPERAND_WIDTH % BLOCK_WIDTH) != 0) begin : gWidthCheck
      $error("OPERAND_WIDTH must be an integer multiple of BLOCK_WIDTH");
    end
  endgenerate

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                   state;
  state_t                   stateNext;
  logic [OPERAND_WIDTH-1:0] aReg;
  logic [OPERAND_WIDTH-1:0] bReg;
  logic                     runCarry;
  logic [CNT_W-1:0]         sliceCnt;

  logic [BLOCK_WIDTH-1:0]   aSlice;
  logic [BLOCK_WIDTH-1:0]   bSlice;
  logic [BLOCK_WIDTH:0]     sumC0;
  logic [BLOCK_WIDTH:0]     sumC1;
  logic [BLOCK_WIDTH:0]     selSum;
  logic                     lastSlice;
  logic                     msbCarryIn;
  logic                     startAccept;

  assign oBusy       = (state == RUN);
  assign startAccept = (state == IDLE) && iStart;

  // Carry-select slice: both candidate sums are formed up front, and the running carry chooses one.
  // The operand registers shift right, so the active slice is always at the bottom.
  always_comb begin
    aSlice     = aReg[BLOCK_WIDTH-1:0];
    bSlice     = bReg[BLOCK_WIDTH-1:0];
    sumC0      = {1'b0, aSlice} + {1'b0, bSlice};
    sumC1      = {1'b0, aSlice} + {1'b0, bSlice} + (BLOCK_WIDTH+1)'(1);
    selSum     = runCarry ? sumC1 : sumC0;
    lastSlice  = (sliceCnt == CNT_W'(NUM_BLOCKS - 1));
    // Carry into the result MSB is recovered from its sum bit and its operand bits.
    msbCarryIn = aSlice[BLOCK_WIDTH-1] ^ bSlice[BLOCK_WIDTH-1] ^ selSum[BLOCK_WIDTH-1];
  end

  // State register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic: start from idle (including the done cycle), return after the last slice.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (iStart)    stateNext = RUN;
      RUN:     if (lastSlice) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: capture the effective operands on start, then resolve one slice per clock.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      aReg      <= '0;
      bReg      <= '0;
      runCarry  <= 1'b0;
      sliceCnt  <= '0;
      oDone     <= 1'b0;
      oSum      <= '0;
      oCarry    <= 1'b0;
      oOverflow <= 1'b0;
    end else begin
      oDone <= 1'b0;
      if (startAccept) begin
        aReg     <= iA;
        bReg     <= iSub ? ~iB : iB;
        runCarry <= iSub ? 1'b1 : iCarry;
        sliceCnt <= '0;
        oSum     <= '0;
      end else if (state == RUN) begin
        aReg     <= aReg >> BLOCK_WIDTH;
        bReg     <= bReg >> BLOCK_WIDTH;
        runCarry <= selSum[BLOCK_WIDTH];
        sliceCnt <= sliceCnt + CNT_W'(1);
        for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
          if (sliceCnt == CNT_W'(i)) oSum[i*BLOCK_WIDTH +: BLOCK_WIDTH] <= selSum[BLOCK_WIDTH-1:0];
        end
        if (lastSlice) begin
          oDone     <= 1'b1;
          oCarry    <= selSum[BLOCK_WIDTH];
          oOverflow <= msbCarryIn ^ selSum[BLOCK_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_multicycle_select_adder.sv
// Scoreboard bench for multicycle_select_adder (32-bit operands, 8-bit slices).
module tb_multicycle_select_adder;

  localparam int OW = 32;
  localparam int BW = 8;
  localparam int NB = OW / BW;

  logic          iClk;
  logic          iRstN;
  logic          iStart;
  logic          iSub;
  logic [OW-1:0] iA;
  logic [OW-1:0] iB;
  logic          iCarry;
  logic          oBusy;
  logic          oDone;
  logic [OW-1:0] oSum;
  logic          oCarry;
  logic          oOverflow;

  multicycle_select_adder #(
    .OPERAND_WIDTH(OW),
    .BLOCK_WIDTH  (BW)
  ) dut (
    .iClk     (iClk),
    .iRstN    (iRstN),
    .iStart   (iStart),
    .iSub     (iSub),
    .iA       (iA),
    .iB       (iB),
    .iCarry   (iCarry),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oSum     (oSum),
    .oCarry   (oCarry),
    .oOverflow(oOverflow)
  );

  typedef struct {
    logic [OW-1:0] sum;
    logic          c;
    logic          v;
    int unsigned   cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned passCnt = 0;
  int unsigned failCnt = 0;
  int unsigned totalCnt = 0;
  int unsigned doneCount = 0;

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else begin
      failCnt++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain full-width arithmetic and signed-range reasoning.
  function automatic exp_t model(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                 input logic c, input logic sub);
    exp_t r;
    logic [OW:0] full;
    if (!sub) begin
      full  = {1'b0, a} + {1'b0, b} + (OW+1)'(c);
      r.sum = full[OW-1:0];
      r.c   = full[OW];
      r.v   = (a[OW-1] == b[OW-1]) && (r.sum[OW-1] != a[OW-1]);
    end else begin
      r.sum = a - b;
      r.c   = (a >= b);
      r.v   = (a[OW-1] != b[OW-1]) && (r.sum[OW-1] != a[OW-1]);
    end
    r.cyc = 0;
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge iClk) begin
    if (iRstN && oDone) begin
      doneCount++;
      if (q.size() == 0) begin
        check("unexpected_done", 64'(oSum), 64'hdead);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sum", 64'(oSum), 64'(e.sum));
        check("carry", 64'(oCarry), 64'(e.c));
        check("overflow", 64'(oOverflow), 64'(e.v));
        check("latency", 64'(cyc - e.cyc), 64'(NB));
      end
    end
  end

  // Called just after a negedge; holds iStart for exactly one rising edge.
  task automatic issue(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic c,
                       input logic sub, input bit push, input exp_t e);
    exp_t ee;
    iA = a; iB = b; iCarry = c; iSub = sub; iStart = 1'b1;
    if (push) begin
      ee = e;
      ee.cyc = cyc + 1;
      q.push_back(ee);
    end
    @(negedge iClk);
    iStart = 1'b0;
    iA = $urandom; iB = $urandom; iCarry = 1'($urandom); iSub = 1'($urandom);
  endtask

  task automatic waitIdle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge iClk);
      if (q.size() == 0 && !oBusy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  function automatic exp_t mk(input logic [OW-1:0] s, input logic c, input logic v);
    exp_t e;
    e.sum = s; e.c = c; e.v = v; e.cyc = 0;
    return e;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned busyCnt;
    int unsigned doneBase;
    logic [OW-1:0] a, b;
    logic c, s;
    iRstN = 1'b0; iStart = 1'b0; iSub = 1'b0; iA = '0; iB = '0; iCarry = 1'b0;
    repeat (3) @(negedge iClk);
    check("reset_outputs", 64'({oBusy, oDone, oSum, oCarry, oOverflow}), 64'd0);
    iRstN = 1'b1;
    @(negedge iClk);

    // Full carry ripple through every slice.
    issue(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1, mk(32'h00000000, 1'b1, 1'b0));
    busyCnt = 0;
    for (int i = 0; i < 20 && !oDone; i++) begin
      if (oBusy) busyCnt++;
      @(negedge iClk);
    end
    check("busy_cycles", 64'(busyCnt), 64'(NB));
    waitIdle(20);

    // Subtract with borrow; iCarry must be ignored.
    issue(32'h00000005, 32'h00000007, 1'b1, 1'b1, 1, mk(32'hFFFFFFFE, 1'b0, 1'b0));
    waitIdle(20);

    // Signed overflow.
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1, mk(32'h80000000, 1'b0, 1'b1));
    waitIdle(20);

    // Start while busy is ignored; start in the done cycle is accepted.
    doneBase = doneCount;
    issue(32'h00000010, 32'h00000020, 1'b0, 1'b0, 1, mk(32'h00000030, 1'b0, 1'b0));
    issue(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 0, mk('0, 1'b0, 1'b0));
    for (int i = 0; i < 20 && !oDone; i++) @(negedge iClk);
    issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1, mk(32'h23456789, 1'b0, 1'b0));
    waitIdle(20);
    repeat (6) @(negedge iClk);
    check("done_pulses", 64'(doneCount - doneBase), 64'd2);

    // Reset mid-operation aborts asynchronously with no done.
    doneBase = doneCount;
    issue(32'hCAFEF00D, 32'h01020304, 1'b0, 1'b0, 0, mk('0, 1'b0, 1'b0));
    @(posedge iClk);
    #2 iRstN = 1'b0;
    #1 check("async_reset_outputs", 64'({oBusy, oDone, oSum, oCarry, oOverflow}), 64'd0);
    repeat (3) @(negedge iClk);
    iRstN = 1'b1;
    repeat (8) @(negedge iClk);
    check("no_done_after_abort", 64'(doneCount - doneBase), 64'd0);
    issue(32'h00000001, 32'h00000001, 1'b0, 1'b0, 1, mk(32'h00000002, 1'b0, 1'b0));
    waitIdle(20);

    // Randomized operations against the reference model.
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'h7FFFFFFF;
        1:       a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'h80000000;
        1:       b = a;
        default: b = $urandom;
      endcase
      c = 1'($urandom);
      s = 1'($urandom);
      issue(a, b, c, s, 1, model(a, b, c, s));
      waitIdle(20);
    end

    repeat (2) @(negedge iClk);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
